// File: rtl/uart_irq_ctrl.sv
// rtl/uart_irq_ctrl.sv - UART interrupt controller: line error, RX trigger, char timeout, TX threshold
// Pending bits are raw state; irq_o/irq_id_o are combinational from pend and enables.
module uart_irq_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CTI_TICKS  = 64,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    irq_en_i,
  input  logic [3:0]    clr_i,
  input  logic [2:0]    err_i,
  input  logic [LW-1:0] rx_elem_i,
  input  logic [LW-1:0] tx_elem_i,
  input  logic [LW-1:0] rx_trg_i,
  input  logic [LW-1:0] tx_trg_i,
  input  logic          rx_push_i,
  input  logic          rx_pop_i,
  input  logic          tx_push_i,
  input  logic          baud_tick_i,
  output logic [3:0]    pend_o,
  output logic [2:0]    lsr_o,
  output logic [1:0]    irq_id_o,
  output logic          irq_o
);

  localparam int CW = $clog2(CTI_TICKS + 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CTI_LAST = CW'(CTI_TICKS - 1);

  logic [3:0]    r_pend;
  logic [2:0]    r_lsr;
  logic [CW-1:0] r_cti_cnt;
  logic          r_thr;

  logic [3:0]    w_pend_n;
  logic [2:0]    w_lsr_n;
  logic [CW-1:0] w_cti_cnt_n;
  logic [LW-1:0] w_rx_trg_eff;
  logic          w_rx_empty;
  logic          w_cti_fire;
  logic          w_thr;
  logic [3:0]    w_masked;

  assign w_rx_trg_eff = (rx_trg_i > DEPTH_L) ? DEPTH_L : rx_trg_i;
  assign w_rx_empty   = (rx_elem_i == '0);
  assign w_thr        = (tx_elem_i <= tx_trg_i);

  always_comb begin
    w_pend_n    = r_pend;
    w_lsr_n     = r_lsr;
    w_cti_cnt_n = r_cti_cnt;
    w_cti_fire  = 1'b0;

    // Line error: a new error beats a same-cycle clear, and only the new causes survive it.
    if (clr_i[0]) begin
      w_lsr_n = err_i;
    end else begin
      w_lsr_n = r_lsr | err_i;
    end
    if (|err_i) begin
      w_pend_n[0] = 1'b1;
    end else if (clr_i[0]) begin
      w_pend_n[0] = 1'b0;
    end

    w_pend_n[1] = (w_rx_trg_eff != '0) && (rx_elem_i >= w_rx_trg_eff);

    if (rx_push_i || rx_pop_i || w_rx_empty) begin
      w_cti_cnt_n = '0;
    end else if (baud_tick_i && (r_cti_cnt == CTI_LAST)) begin
      w_cti_cnt_n = '0;
      w_cti_fire  = 1'b1;
    end else if (baud_tick_i && !r_pend[2]) begin
      w_cti_cnt_n = r_cti_cnt + CW'(1);
    end
    if (w_cti_fire) begin
      w_pend_n[2] = 1'b1;
    end else if (rx_pop_i || w_rx_empty || clr_i[2]) begin
      w_pend_n[2] = 1'b0;
    end

    // TX threshold is edge-triggered so a cleared bit stays quiet while the level persists.
    if (w_thr && !r_thr) begin
      w_pend_n[3] = 1'b1;
    end else if (clr_i[3] || tx_push_i) begin
      w_pend_n[3] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend    <= '0;
      r_lsr     <= '0;
      r_cti_cnt <= '0;
      r_thr     <= 1'b0;
    end else begin
      r_pend    <= w_pend_n;
      r_lsr     <= w_lsr_n;
      r_cti_cnt <= w_cti_cnt_n;
      r_thr     <= w_thr;
    end
  end

  assign w_masked = r_pend & irq_en_i;

  always_comb begin
    irq_id_o = 2'd0;
    if (w_masked[0]) begin
      irq_id_o = 2'd0;
    end else if (w_masked[1]) begin
      irq_id_o = 2'd1;
    end else if (w_masked[2]) begin
      irq_id_o = 2'd2;
    end else if (w_masked[3]) begin
      irq_id_o = 2'd3;
    end
  end

  assign irq_o  = |w_masked;
  assign pend_o = r_pend;
  assign lsr_o  = r_lsr;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb/tb_uart_irq_ctrl.sv - directed vector bench for uart_irq_ctrl (FIFO_DEPTH=16, CTI_TICKS=4)
module tb_uart_irq_ctrl;
  localparam int LW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [3:0]    irq_en_i;
  logic [3:0]    clr_i;
  logic [2:0]    err_i;
  logic [LW-1:0] rx_elem_i, tx_elem_i, rx_trg_i, tx_trg_i;
  logic          rx_push_i, rx_pop_i, tx_push_i, baud_tick_i;
  logic [3:0]    pend_o;
  logic [2:0]    lsr_o;
  logic [1:0]    irq_id_o;
  logic          irq_o;

  int total = 0;
  int bad   = 0;

  uart_irq_ctrl #(.FIFO_DEPTH(16), .CTI_TICKS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_en_i(irq_en_i), .clr_i(clr_i), .err_i(err_i),
    .rx_elem_i(rx_elem_i), .tx_elem_i(tx_elem_i), .rx_trg_i(rx_trg_i), .tx_trg_i(tx_trg_i),
    .rx_push_i(rx_push_i), .rx_pop_i(rx_pop_i), .tx_push_i(tx_push_i), .baud_tick_i(baud_tick_i),
    .pend_o(pend_o), .lsr_o(lsr_o), .irq_id_o(irq_id_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // strb = {rx_push, rx_pop, tx_push, baud_tick}
  typedef struct {
    logic       rst;
    logic [3:0] en, clr;
    logic [2:0] err;
    int         rxe, txe, rxt, txt;
    logic [3:0] strb;
    logic [3:0] e_pend;
    logic [2:0] e_lsr;
    logic [1:0] e_id;
    logic       e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] en, input logic [3:0] clr,
                     input logic [2:0] err, input int rxe, input int txe, input int rxt,
                     input int txt, input logic [3:0] strb, input logic [3:0] e_pend,
                     input logic [2:0] e_lsr, input logic [1:0] e_id, input logic e_irq);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.err = err;
    v.rxe = rxe; v.txe = txe; v.rxt = rxt; v.txt = txt; v.strb = strb;
    v.e_pend = e_pend; v.e_lsr = e_lsr; v.e_id = e_id; v.e_irq = e_irq;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_i       = v.rst;
    irq_en_i    = v.en;
    clr_i       = v.clr;
    err_i       = v.err;
    rx_elem_i   = LW'(v.rxe);
    tx_elem_i   = LW'(v.txe);
    rx_trg_i    = LW'(v.rxt);
    tx_trg_i    = LW'(v.txt);
    rx_push_i   = v.strb[3];
    rx_pop_i    = v.strb[2];
    tx_push_i   = v.strb[1];
    baud_tick_i = v.strb[0];
  endtask

  initial begin
    int cycles;
    vec_t v;
    //   rst en       clr      err     rxe txe rxt txt strb     pend     lsr     id  irq
    add(1, 4'b1111, 4'b0000, 3'b111, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(1, 4'b1111, 4'b0000, 3'b111, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b010, 0, 5, 0, 0, 4'b0000, 4'b0001, 3'b010, 0, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0001, 3'b010, 0, 1);
    add(0, 4'b1111, 4'b0001, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b100, 0, 5, 0, 0, 4'b0000, 4'b0001, 3'b100, 0, 1);
    add(0, 4'b1111, 4'b0001, 3'b001, 0, 5, 0, 0, 4'b0000, 4'b0001, 3'b001, 0, 1);
    add(0, 4'b1111, 4'b0001, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    // RX trigger level, clamp to depth, zero trigger disables
    add(0, 4'b1111, 4'b0000, 3'b000, 7, 5, 8, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 8, 5, 8, 0, 4'b0000, 4'b0010, 3'b000, 1, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 9, 5, 8, 0, 4'b0000, 4'b0010, 3'b000, 1, 1);
    add(0, 4'b1111, 4'b0010, 3'b000, 9, 5, 8, 0, 4'b0000, 4'b0010, 3'b000, 1, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 7, 5, 8, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 16, 5, 20, 0, 4'b0000, 4'b0010, 3'b000, 1, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 15, 5, 20, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 16, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    // char timeout: fires on 4th tick, holds, W1C
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0100, 3'b000, 2, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0100, 3'b000, 2, 1);
    add(0, 4'b1111, 4'b0100, 3'b000, 3, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    // pop after 3 ticks restarts the count
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0100, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    // fire colliding with clr_i[2]: set wins; empty FIFO then clears
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0100, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0100, 3'b000, 2, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    // TX threshold edge behaviour
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 5, 0, 2, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 2, 0, 2, 4'b0000, 4'b1000, 3'b000, 3, 1);
    add(0, 4'b1111, 4'b1000, 3'b000, 0, 1, 0, 2, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 1, 0, 2, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 3, 0, 2, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 2, 0, 2, 4'b0000, 4'b1000, 3'b000, 3, 1);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 2, 0, 2, 4'b0010, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 3, 0, 2, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b1000, 3'b000, 0, 2, 0, 2, 4'b0000, 4'b1000, 3'b000, 3, 1);
    // build pend=1110 under mask 1000, then mask off / on
    add(0, 4'b1000, 4'b0000, 3'b000, 8, 2, 8, 2, 4'b0001, 4'b1010, 3'b000, 3, 1);
    add(0, 4'b1000, 4'b0000, 3'b000, 8, 2, 8, 2, 4'b0001, 4'b1010, 3'b000, 3, 1);
    add(0, 4'b1000, 4'b0000, 3'b000, 8, 2, 8, 2, 4'b0001, 4'b1010, 3'b000, 3, 1);
    add(0, 4'b1000, 4'b0000, 3'b000, 8, 2, 8, 2, 4'b0001, 4'b1110, 3'b000, 3, 1);
    add(0, 4'b0000, 4'b0000, 3'b000, 8, 2, 8, 2, 4'b0000, 4'b1110, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 8, 2, 8, 2, 4'b0000, 4'b1110, 3'b000, 1, 1);
    // mid-operation reset discards pending bits and in-flight counts
    add(1, 4'b1111, 4'b0000, 3'b111, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 0, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(1, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0000, 3'b000, 0, 0);
    add(0, 4'b1111, 4'b0000, 3'b000, 3, 5, 0, 0, 4'b0001, 4'b0100, 3'b000, 2, 1);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk_i);
      #1;
      check("pend", i, pend_o, vecs[i].e_pend);
      check("lsr", i, {1'b0, lsr_o}, {1'b0, vecs[i].e_lsr});
      check("irq_id", i, {2'b0, irq_id_o}, {2'b0, vecs[i].e_id});
      check("irq", i, {3'b0, irq_o}, {3'b0, vecs[i].e_irq});
    end

    // irq_o follows irq_en_i with no clock edge (pend = 0100 here)
    v = vecs[vecs.size()-1];
    v.strb = 4'b0000;
    v.en = 4'b0000;
    drive(v);
    #1;
    check("comb_mask_irq", 100, {3'b0, irq_o}, 4'h0);
    irq_en_i = 4'b0100;
    #1;
    check("comb_en_irq", 101, {3'b0, irq_o}, 4'h1);
    check("comb_en_id", 102, {2'b0, irq_id_o}, 4'h2);

    // clear, then count ticks until the timeout re-fires
    clr_i = 4'b0100;
    @(posedge clk_i);
    #1;
    clr_i = 4'b0000;
    check("cti_cleared", 103, pend_o, 4'b0000);
    baud_tick_i = 1'b1;
    cycles = 0;
    while (pend_o[2] !== 1'b1 && cycles < 20) begin
      @(posedge clk_i);
      #1;
      cycles++;
    end
    baud_tick_i = 1'b0;
    check("cti_latency", 104, 4'(cycles), 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
